enhanced_fifo_core: RTL

//  Synchronous byte FIFO directly downstream of the CPU-side write/read driver: accepts WR_EN/FIFO_IN pushes and RD_EN pops.

---
 rtl/enhanced_fifo_pkg.sv | 33 +++
 rtl/fifo_ram.sv | 27 ++
 rtl/enhanced_fifo_core.sv | 112 +++++++++++
 3 files changed

// File: rtl/enhanced_fifo_pkg.sv
// Shared constants and types for the enhanced byte FIFO.
// Default geometry, threshold defaults, pointer/count types and the status flag bundle.
package enhanced_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_AF_THRESH = 14;
    localparam int DEF_AE_THRESH = 2;

    // Pointers carry one wrap bit above the memory index; the count needs the same width.
    typedef logic [DEF_ADDR_W:0] ptr_t;
    typedef logic [DEF_ADDR_W:0] cnt_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: no reset on the array; occupancy is tracked by the pointers, so stale
    // contents are never observed and the array can map onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/enhanced_fifo_core.sv
// Synchronous byte FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read on pop.
module enhanced_fifo_core
    import enhanced_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic              SYSCLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] FIFO_IN,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] FIFO_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [ADDR_W:0]   FIFO_CNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  cnt_q, cnt_d;
    fifo_flags_t       flags_q, flags_d;
    logic              pop_acc, push_acc;
    logic [DATA_W-1:0] rd_data;

    // NOTE: every output of this block is given a value before any condition is
    // evaluated, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        pop_acc  = RD_EN && !flags_q.empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
        push_acc = WR_EN && (!flags_q.full || pop_acc);

        wr_ptr_d = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_acc);
        cnt_d    = wr_ptr_d - rd_ptr_d;

        flags_d              = flags_q;
        flags_d.full         = (cnt_d == PTR_W'(DEPTH));
        flags_d.empty        = (cnt_d == '0);
        flags_d.almost_full  = (cnt_d >= PTR_W'(AF_THRESH));
        flags_d.almost_empty = (cnt_d <= PTR_W'(AE_THRESH));
        flags_d.overflow     = flags_q.overflow  || (WR_EN && !push_acc);
        flags_d.underflow    = flags_q.underflow || (RD_EN && !pop_acc);
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            flags_q  <= FLAGS_RESET;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (SYSCLK),
        .we_i    (push_acc && !RST),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (FIFO_IN),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

`ifdef FIFO_FWFT_EN
    // Head entry is always presented; RD_EN only acknowledges it.
    assign FIFO_OUT = rd_data;
`else
    logic [DATA_W-1:0] dout_q;

    // When full with a simultaneous push, the write lands on this slot at the same
    // edge; the read still captures the old head because the array updates afterwards.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            dout_q <= '0;
        end else if (pop_acc) begin
            dout_q <= rd_data;
        end
    end

    assign FIFO_OUT = dout_q;
`endif

    assign FIFO_CNT     = cnt_q;
    assign FULL         = flags_q.full;
    assign EMPTY        = flags_q.empty;
    assign ALMOST_FULL  = flags_q.almost_full;
    assign ALMOST_EMPTY = flags_q.almost_empty;
    assign OVERFLOW     = flags_q.overflow;
    assign UNDERFLOW    = flags_q.underflow;

endmodule
